stream_mux_rr: RTL and testbench

STREAM_MUX_RR -- requirements
Module: stream_mux_rr

---
 rtl/stream_mux_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/stream_mux_rr.sv | 95 +++++++++
 tb/tb_stream_mux_rr.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// Shared constants and the select/source index width helper for the stream mux.
package stream_mux_pkg;

  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;

  // Index width for n channels, never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or above ptr, wrapping.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = sel_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  int best;
  int off;

  // Distance from ptr (mod N) ranks the requesters; the nearest one wins.
  always_comb begin
    best      = N;
    off       = 0;
    grant_idx = '0;
    for (int k = 0; k < N; k++) begin
      off = (k + N - int'(ptr)) % N;
      if (req[k] && off < best) begin
        best      = off;
        grant_idx = IW'(k);
      end
    end
    for (int k = 0; k < N; k++)
      grant[k] = (best < N) && (grant_idx == IW'(k));
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-to-1 stream mux with a one-word output register; external-select or round-robin policy.
// Define STREAM_MUX_PARITY_EN to add the registered out_par bit.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter  int WIDTH  = 16,
  parameter  int NUM_IN = 4,
  parameter  int MODE   = MODE_SEL,
  localparam int SEL_W  = sel_width(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_src
`ifdef STREAM_MUX_PARITY_EN
  ,
  output logic                    out_par
`endif
);

  logic              load;
  logic              take;
  logic [NUM_IN-1:0] grant;
  logic [SEL_W-1:0]  pick_idx;
  logic [WIDTH-1:0]  word;

  assign load = !out_valid || out_ready;

  generate
    if (MODE == MODE_RR) begin : g_rr
      logic [SEL_W-1:0] ptr;

      rr_arbiter #(.N(NUM_IN)) u_arb (
        .req       (in_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (pick_idx)
      );

      // Pointer moves past the winner only when its word is actually taken.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          ptr <= '0;
        else if (load && |grant)
          ptr <= (int'(pick_idx) == NUM_IN - 1) ? '0 : pick_idx + 1'b1;
      end
    end else begin : g_sel
      // An out-of-range sel matches no channel, so nothing is granted.
      always_comb begin
        for (int k = 0; k < NUM_IN; k++)
          grant[k] = in_valid[k] && (sel == SEL_W'(k));
      end
      assign pick_idx = sel;
    end
  endgenerate

  assign take     = load && |grant;
  assign in_ready = (rst_n && load) ? grant : '0;

  always_comb begin
    word = '0;
    for (int k = 0; k < NUM_IN; k++)
      if (grant[k]) word = in_data[k*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else if (load) begin
      out_valid <= take;
      if (take) begin
        out_data <= word;
        out_src  <= pick_idx;
      end
    end
  end

`ifdef STREAM_MUX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      out_par <= 1'b0;
    else if (take)
      out_par <= ^word;
  end
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Randomized plus directed bench: select-mode and round-robin instances against a queue-free reference model.
module tb_stream_mux_rr;
  localparam int W  = 16;
  localparam int N  = 4;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [SW-1:0]  sel;
  logic           out_ready;
  logic [N-1:0]   rdy0, rdy1;
  logic [W-1:0]   od0, od1;
  logic           ov0, ov1;
  logic [SW-1:0]  os0, os1;
`ifdef STREAM_MUX_PARITY_EN
  logic           op0, op1;
`endif

  always #5 clk = ~clk;

  stream_mux_rr #(.WIDTH(W), .NUM_IN(N), .MODE(0)) dut_sel (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy0),
    .sel(sel), .out_data(od0), .out_valid(ov0), .out_ready(out_ready), .out_src(os0)
`ifdef STREAM_MUX_PARITY_EN
    , .out_par(op0)
`endif
  );

  stream_mux_rr #(.WIDTH(W), .NUM_IN(N), .MODE(1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy1),
    .sel(sel), .out_data(od1), .out_valid(ov1), .out_ready(out_ready), .out_src(os1)
`ifdef STREAM_MUX_PARITY_EN
    , .out_par(op1)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference state: index 0 = select mode, 1 = round-robin.
  bit         m_vld [2];
  logic [W-1:0] m_data [2];
  int         m_src [2];
  int         m_ptr;

  function automatic int pick(input int d);
    if (d == 0) return in_valid[sel] ? int'(sel) : -1;
    for (int i = 0; i < N; i++)
      if (in_valid[(m_ptr + i) % N]) return (m_ptr + i) % N;
    return -1;
  endfunction

  function automatic logic [W-1:0] chan(input int k);
    logic [N*W-1:0] d;
    d = in_data;
    return d[k*W +: W];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_vld[d] = 0; m_data[d] = '0; m_src[d] = 0;
    end
    m_ptr = 0;
  endtask

  // Called just after a negedge with inputs applied; returns at the next negedge.
  task automatic step();
    int k [2];
    bit ld [2];
    #1;
    for (int d = 0; d < 2; d++) begin
      ld[d] = !m_vld[d] || out_ready;
      k[d]  = pick(d);
    end
    check("in_ready_sel", 32'(rdy0), (ld[0] && k[0] >= 0) ? 32'(1 << k[0]) : 32'd0);
    check("in_ready_rr",  32'(rdy1), (ld[1] && k[1] >= 0) ? 32'(1 << k[1]) : 32'd0);
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (ld[d]) begin
        m_vld[d] = (k[d] >= 0);
        if (k[d] >= 0) begin
          m_data[d] = chan(k[d]);
          m_src[d]  = k[d];
          if (d == 1) m_ptr = (k[d] + 1) % N;
        end
      end
    end
    #1;
    check("out_valid_sel", 32'(ov0), 32'(m_vld[0]));
    check("out_data_sel",  32'(od0), 32'(m_data[0]));
    check("out_src_sel",   32'(os0), 32'(m_src[0]));
    check("out_valid_rr",  32'(ov1), 32'(m_vld[1]));
    check("out_data_rr",   32'(od1), 32'(m_data[1]));
    check("out_src_rr",    32'(os1), 32'(m_src[1]));
`ifdef STREAM_MUX_PARITY_EN
    check("out_par_sel", 32'(op0), 32'(^m_data[0]));
    check("out_par_rr",  32'(op1), 32'(^m_data[1]));
`endif
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_valid_sel", 32'(ov0), 32'd0);
    check("rst_valid_rr",  32'(ov1), 32'd0);
    check("rst_data_rr",   32'(od1), 32'd0);
    check("rst_src_rr",    32'(os1), 32'd0);
    check("rst_ready",     32'({rdy0, rdy1}), 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_chans(input logic [W-1:0] a, b, c, d);
    in_data = {d, c, b, a};
  endtask

  initial begin
    int exp_seq [5];
    in_data = '0; in_valid = '0; sel = '0; out_ready = 1'b1;
    do_reset();

    // Select mode: sel=2 takes channel 2.
    sel = 2; in_valid = 4'b0100; set_chans(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    #1 check("sel2_ready", 32'(rdy0), 32'h4);
    step();
    check("sel2_data", 32'(od0), 32'h3333);
    check("sel2_src",  32'(os0), 32'd2);

    // Stall holds BEEF for three cycles, then the next word loads.
    sel = 0; in_valid = 4'b0001; set_chans(16'hBEEF, 16'h0, 16'h0, 16'h0);
    step();
    out_ready = 1'b0; set_chans(16'h1234, 16'h0, 16'h0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_data", 32'(od0), 32'hBEEF);
    end
    out_ready = 1'b1;
    step();
    check("after_stall", 32'(od0), 32'h1234);

    // Round-robin over all four channels.
    do_reset();
    in_valid = 4'b1111; set_chans(16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD);
    exp_seq = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) begin
      step();
      check("rr_all_src", 32'(os1), 32'(exp_seq[i]));
    end

    // Only channels 1 and 3, with an idle gap that must not move the pointer.
    do_reset();
    in_valid = 4'b1010;
    step(); check("rr13_a", 32'(os1), 32'd1);
    step(); check("rr13_b", 32'(os1), 32'd3);
    in_valid = 4'b0000;
    step(); step();
    in_valid = 4'b1010;
    step(); check("rr13_c", 32'(os1), 32'd1);
    step(); check("rr13_d", 32'(os1), 32'd3);

    // Asynchronous reset between edges, mid-stream.
    in_valid = 4'b1111;
    step(); step();
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_valid_sel", 32'(ov0), 32'd0);
    check("async_valid_rr",  32'(ov1), 32'd0);
    check("async_ready",     32'({rdy0, rdy1}), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_rst_src", 32'(os1), 32'd0);

`ifdef STREAM_MUX_PARITY_EN
    sel = 0; in_valid = 4'b0001; set_chans(16'h0001, 16'h0, 16'h0, 16'h0);
    step(); check("par_0001", 32'(op0), 32'd1);
    set_chans(16'hFFFF, 16'h0, 16'h0, 16'h0);
    step(); check("par_ffff", 32'(op0), 32'd0);
`endif

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      in_valid  = N'($urandom);
      sel       = SW'($urandom);
      in_data   = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
